// File: rtl/tap_decoder.sv
// Tap-gesture decoder: groups debounced presses that fall inside a timeout window into single/double/triple tap events.
// Optional sticky last-event output is enabled by defining TAP_LAST_EVENT_EN.
module tap_decoder #(
  parameter int TAP_WINDOW = 30000000,
  parameter int TIMER_W    = 25
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pressPulse,
  output logic       singleTap,
  output logic       doubleTap,
  output logic       tripleTap,
  output logic [1:0] tapCount,
  output logic       busy
`ifdef TAP_LAST_EVENT_EN
  ,
  output logic [1:0] lastEvent
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } tapState_t;

  localparam logic [TIMER_W-1:0] LAST_TICK = TIMER_W'(TAP_WINDOW - 1);

  tapState_t          stateReg;
  tapState_t          stateNext;
  logic [TIMER_W-1:0] timerReg;
  logic [TIMER_W-1:0] timerNext;
  logic [1:0]         countNext;
  logic               singleNext;
  logic               doubleNext;
  logic               tripleNext;

  // Next-state, window timer and event decode; a press always beats a coincident timeout.
  always_comb begin
    stateNext  = stateReg;
    timerNext  = timerReg;
    countNext  = tapCount;
    singleNext = 1'b0;
    doubleNext = 1'b0;
    tripleNext = 1'b0;
    case (stateReg)
      IDLE: begin
        if (pressPulse) begin
          stateNext = WAIT;
          countNext = 2'd1;
          timerNext = '0;
        end else begin
          countNext = 2'd0;
          timerNext = '0;
        end
      end
      WAIT: begin
        if (pressPulse) begin
          if (tapCount < 2'd2) begin
            countNext = tapCount + 2'd1;
            timerNext = '0;
          end else begin
            tripleNext = 1'b1;
            stateNext  = IDLE;
            countNext  = 2'd0;
            timerNext  = '0;
          end
        end else if (timerReg == LAST_TICK) begin
          singleNext = (tapCount == 2'd1);
          doubleNext = (tapCount == 2'd2);
          stateNext  = IDLE;
          countNext  = 2'd0;
          timerNext  = '0;
        end else begin
          timerNext = timerReg + TIMER_W'(1);
        end
      end
      default: begin
        stateNext = IDLE;
        countNext = 2'd0;
        timerNext = '0;
      end
    endcase
  end

  // State, timer and all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      stateReg  <= IDLE;
      timerReg  <= '0;
      tapCount  <= 2'd0;
      busy      <= 1'b0;
      singleTap <= 1'b0;
      doubleTap <= 1'b0;
      tripleTap <= 1'b0;
    end else begin
      stateReg  <= stateNext;
      timerReg  <= timerNext;
      tapCount  <= countNext;
      busy      <= (stateNext == WAIT);
      singleTap <= singleNext;
      doubleTap <= doubleNext;
      tripleTap <= tripleNext;
    end
  end

`ifdef TAP_LAST_EVENT_EN
  function automatic logic [1:0] eventCode(input logic s, input logic d, input logic t);
    logic [1:0] code;
    if (t) begin
      code = 2'b11;
    end else if (d) begin
      code = 2'b10;
    end else if (s) begin
      code = 2'b01;
    end else begin
      code = 2'b00;
    end
    return code;
  endfunction

  // Sticky record of the most recent gesture, updated alongside its strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      lastEvent <= 2'b00;
    end else if (singleNext || doubleNext || tripleNext) begin
      lastEvent <= eventCode(singleNext, doubleNext, tripleNext);
    end else begin
      lastEvent <= lastEvent;
    end
  end
`endif

endmodule

// File: tb/tb_tap_decoder.sv
// Directed self-checking bench for tap_decoder with TAP_WINDOW=10; each scenario
// is a table of per-cycle masks (bit c = value during cycle c of the scenario).
module tb_tap_decoder;

  logic       clock;
  logic       reset;
  logic       pressPulse;
  logic       singleTap;
  logic       doubleTap;
  logic       tripleTap;
  logic [1:0] tapCount;
  logic       busy;
`ifdef TAP_LAST_EVENT_EN
  logic [1:0] lastEvent;
`endif

  int checks = 0;
  int errors = 0;

  tap_decoder #(.TAP_WINDOW(10), .TIMER_W(25)) dut (
    .clock      (clock),
    .reset      (reset),
    .pressPulse (pressPulse),
    .singleTap  (singleTap),
    .doubleTap  (doubleTap),
    .tripleTap  (tripleTap),
    .tapCount   (tapCount),
    .busy       (busy)
`ifdef TAP_LAST_EVENT_EN
    ,
    .lastEvent  (lastEvent)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m;
    m = 64'd0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic check(input string tag, input int cyc, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // Checks outputs at the start of each cycle, then drives that cycle's inputs.
  task automatic scenario(input string name, input int nCyc,
                          input logic [63:0] pressM, input logic [63:0] rstM,
                          input logic [63:0] singleM, input logic [63:0] doubleM,
                          input logic [63:0] tripleM, input logic [63:0] busyM,
                          input logic [63:0] cntLoM, input logic [63:0] cntHiM);
    for (int c = 0; c < nCyc; c++) begin
      if (c > 0) begin
        check({name, ".single"}, c, {1'b0, singleTap}, {1'b0, singleM[c]});
        check({name, ".double"}, c, {1'b0, doubleTap}, {1'b0, doubleM[c]});
        check({name, ".triple"}, c, {1'b0, tripleTap}, {1'b0, tripleM[c]});
        check({name, ".busy"},   c, {1'b0, busy},      {1'b0, busyM[c]});
        check({name, ".tapCount"}, c, tapCount, {cntHiM[c], cntLoM[c]});
      end
      pressPulse = pressM[c];
      reset      = rstM[c];
      @(posedge clock);
      #1;
    end
    pressPulse = 1'b0;
    reset      = 1'b0;
  endtask

  initial begin
    pressPulse = 1'b0;
    reset      = 1'b1;

    // Single press at 5: busy 6..15, single strobe at 16.
    scenario("single", 20, rng(5, 5), rng(0, 2),
             rng(16, 16), 64'd0, 64'd0, rng(6, 15), rng(6, 15), 64'd0);
`ifdef TAP_LAST_EVENT_EN
    check("single.lastEvent", 20, lastEvent, 2'b01);
`endif

    // Presses at 5 and 12: count 2 from 13, double strobe at 23.
    scenario("double", 26, rng(5, 5) | rng(12, 12), rng(0, 2),
             64'd0, rng(23, 23), 64'd0, rng(6, 22), rng(6, 12), rng(13, 22));
`ifdef TAP_LAST_EVENT_EN
    check("double.lastEvent", 26, lastEvent, 2'b10);
`endif

    // Presses at 5, 8, 11 close immediately (triple at 12); press at 12 opens a new gesture.
    scenario("triple", 26, rng(5, 5) | rng(8, 8) | rng(11, 12), rng(0, 2),
             rng(23, 23), 64'd0, rng(12, 12), rng(6, 11) | rng(13, 22),
             rng(6, 8) | rng(13, 22), rng(9, 11));
`ifdef TAP_LAST_EVENT_EN
    check("triple.lastEvent", 26, lastEvent, 2'b01);
`endif

    // Second press coincides with the timeout: press wins, double at 26.
    scenario("coincide", 29, rng(5, 5) | rng(15, 15), rng(0, 2),
             64'd0, rng(26, 26), 64'd0, rng(6, 25), rng(6, 15), rng(16, 25));
`ifdef TAP_LAST_EVENT_EN
    check("coincide.lastEvent", 29, lastEvent, 2'b10);
`endif

    // Reset mid-gesture at 10 discards it; nothing fires afterwards.
    scenario("midreset", 30, rng(5, 5) | rng(8, 8), rng(0, 2) | rng(10, 10),
             64'd0, 64'd0, 64'd0, rng(6, 10), rng(6, 8), rng(9, 10));
`ifdef TAP_LAST_EVENT_EN
    check("midreset.lastEvent", 30, lastEvent, 2'b00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
